piso_nbit_tx: RTL
=================

// Module: piso_nbit_tx
// PURPOSE
//   Parallel-in/serial-out transmitter: accepts N-bit words over a valid/ready handshake
//   and emits them one bit per clk on d_out, LSB first by default.
//   Sits directly upstream of the N-stage shift-right SISO register chain and drives its d_in.
//   A one-word holding buffer allows back-to-back frames with no idle bit between words.
// PARAMETERS
//   N          4   word width in bits; N >= 2
//   MSB_FIRST  0   0 = bit 0 sent first; 1 = bit N-1 sent first
// PORTS
//   clk          in   1   rising-edge clock
//   reset_al_in  in   1   reset, asynchronous, active-low
//   din          in   N   parallel word to transmit
//   din_valid    in   1   din holds a word
//   din_ready    out  1   block can take a word this cycle
//   d_out        out  1   serial data bit (feeds downstream SISO d_in)
//   frame_out    out  1   high while d_out carries a valid data bit
//   last_out     out  1   high on the final bit of each word
// BEHAVIOUR
//   - Reset (async, reset_al_in=0): state=IDLE; shift reg, holding buffer, hbuf_full and bit
//     counter cleared; d_out=0, frame_out=0, last_out=0 immediately; din_ready=0 while in reset.
//     Reset mid-frame aborts the word in flight and discards any buffered word.
//   - Handshake: transfer occurs on a rising edge where din_valid & din_ready.
//     din_ready = ~hbuf_full (registered-state decode, no dependency on din_valid).
//   - States: IDLE, SHIFT. Bit counter cnt is $clog2(N) bits wide, counts 0..N-1.
//   - IDLE: transfer loads din into shift reg, cnt=0, go SHIFT. First bit is on d_out after that
//     same edge (latency 1 clk from accepting edge to first bit). No transfer: stay IDLE.
//   - SHIFT, cnt < N-1: shift reg moves one bit (right if MSB_FIRST=0, left if 1); cnt++.
//     A transfer here writes din into holding buffer, sets hbuf_full.
//   - SHIFT, cnt == N-1 (last bit on d_out, last_out=1), at the next edge:
//       hbuf_full        -> load shift reg from buffer, clear hbuf_full, cnt=0, stay SHIFT
//       ~hbuf_full & xfer -> load shift reg directly from din, cnt=0, stay SHIFT
//       otherwise        -> go IDLE
//     hbuf_full and a new transfer cannot coincide (din_ready=0 when full).
//   - Outputs are registered: d_out = shift reg bit 0 (MSB_FIRST=0) or bit N-1 (MSB_FIRST=1)
//     in SHIFT, forced 0 in IDLE; frame_out = (state==SHIFT); last_out = SHIFT & cnt==N-1.
//   - Each word produces exactly N consecutive frame_out cycles; back-to-back words give an
//     unbroken frame_out with last_out pulsing every N cycles.
//   - din is sampled only on the transfer edge; din changes at other times are ignored.
// TESTING (N=4 unless noted)
//   1 Reset: pull reset_al_in low mid-word -> d_out/frame_out/last_out=0 without a clk edge,
//     din_ready=0; release -> din_ready=1, IDLE, no bits emitted until a transfer.
//   2 Single word din=4'b1011, one-cycle valid -> d_out 1,1,0,1 on the 4 clks after accept;
//     frame_out high exactly 4 clks; last_out high only on the 4th; then IDLE.
//   3 Back-to-back: din_valid held, 4'hA then 4'h5 -> 8 contiguous bits 0,1,0,1,1,0,1,0;
//     din_ready low from buffering of 4'h5 until its load; no gap in frame_out.
//   4 MSB_FIRST=1, din=4'b1000 -> d_out 1,0,0,0; last_out on the 0.
//   5 Chain: d_out into a downstream 4-stage shift-right SISO register (d_in enters at MSB)
//     -> after the 4 frame clocks of 4'b0110 its parallel contents equal 4'b0110.
//   6 Stall: valid drops for 3 clks between words 4'h3 and 4'hC -> frame_out low exactly
//     3 clks between frames; both words delivered intact, none lost or duplicated.

Source files
------------

// File: rtl/piso_nbit_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_nbit_tx
// Purpose  : Parallel-in/serial-out transmitter. Accepts N-bit words over a
//            valid/ready handshake and emits one bit per clk on d_out, with
//            a one-word holding buffer so back-to-back words stream without
//            an idle bit. Drives the d_in of a downstream SISO chain.
// Revision : 1.0  initial release
// ============================================================================
module piso_nbit_tx #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         d_out,
  output logic         frame_out,
  output logic         last_out
);

  localparam int                 c_cnt_w    = $clog2(N);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [N-1:0]       r_shift;
  logic [N-1:0]       r_hbuf;
  logic               r_hbuf_full;
  logic [c_cnt_w-1:0] r_cnt;
  logic [N-1:0]       w_shift_adv;
  logic               w_out_bit;
  logic               w_xfer;
  logic               w_last;

  // Bit order selects the shift direction and which end of the register is on the wire
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_adv = {r_shift[N-2:0], 1'b0};
      assign w_out_bit   = r_shift[N-1];
    end else begin : g_lsb_first
      assign w_shift_adv = {1'b0, r_shift[N-1:1]};
      assign w_out_bit   = r_shift[0];
    end
  endgenerate

  // Ready depends only on registered state; held low while reset is asserted
  assign din_ready = reset_al_in & ~r_hbuf_full;
  assign w_xfer    = din_valid & din_ready;
  assign w_last    = (r_state == c_st_shift) && (r_cnt == c_cnt_last);

  // State register
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) r_state <= c_st_idle;
    else              r_state <= w_state_nxt;
  end

  // Next-state decode: leave SHIFT only when the last bit goes out with nothing queued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_xfer) w_state_nxt = c_st_shift;
      c_st_shift: if (w_last && !r_hbuf_full && !w_xfer) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Datapath: shift register, bit counter and one-word holding buffer
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_shift     <= '0;
      r_hbuf      <= '0;
      r_hbuf_full <= 1'b0;
      r_cnt       <= '0;
    end else if (r_state == c_st_idle) begin
      if (w_xfer) begin
        r_shift <= din;
        r_cnt   <= '0;
      end
    end else if (!w_last) begin
      r_shift <= w_shift_adv;
      r_cnt   <= r_cnt + 1'b1;
      if (w_xfer) begin
        r_hbuf      <= din;
        r_hbuf_full <= 1'b1;
      end
    end else if (r_hbuf_full) begin
      r_shift     <= r_hbuf;
      r_hbuf_full <= 1'b0;
      r_cnt       <= '0;
    end else if (w_xfer) begin
      r_shift <= din;
      r_cnt   <= '0;
    end
  end

  // Output decode from registered state; the wire idles at 0 outside a frame
  always_comb begin
    d_out     = 1'b0;
    frame_out = 1'b0;
    last_out  = 1'b0;
    if (r_state == c_st_shift) begin
      d_out     = w_out_bit;
      frame_out = 1'b1;
      last_out  = w_last;
    end
  end

endmodule
`default_nettype wire
